ninjin_ddr_buffer: RTL and testbench

- Bridges a 16-bit word-addressed accelerator memory port (mem_*) to a 32-bit DDR burst port (ddr_*).
- On a setup request it prefetches the first burst of a read region into a persistent pre-buffer.
- It streams the rest of the read region through two ping-pong buffers.
- It packs host writes into 32-bit entries and flushes them as DDR write bursts.
- Sits between the ninjin accelerator core and the DDR DMA master.

---
 rtl/ninjin_ddr_buffer_if.sv | 44 ++++
 rtl/ninjin_ddr_buffer.sv | 211 +++++++++++++++++++++
 tb/tb_ninjin_ddr_buffer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ninjin_ddr_buffer_if.sv
// Purpose: bundles the setup, host memory and DDR burst signals of ninjin_ddr_buffer.
// Latency: none, plain wiring; the slave modport is the buffer, master is the core/DMA side.
// Backpressure: none; the host paces accesses and the DDR side paces beats.
// Ports: pre_* setup handshake, mem_* 16-bit host port, ddr_* 32-bit burst port, probe_state debug.
interface ninjin_ddr_buffer_if #(
  parameter int DWIDTH   = 16,
  parameter int BWIDTH   = 32,
  parameter int LSB      = 2,
  parameter int WORDSIZE = 32,
  parameter int MEMSIZE  = 32,
  parameter int LWIDTH   = 16
);
  logic                       pre_req;
  logic [WORDSIZE-1:0]        pre_base;
  logic [LWIDTH-1:0]          read_len;
  logic [LWIDTH-1:0]          write_len;
  logic                       pre_ack;
  logic                       mem_we;
  logic [MEMSIZE-1:0]         mem_addr;
  logic signed [DWIDTH-1:0]   mem_wdata;
  logic signed [DWIDTH-1:0]   mem_rdata;
  logic                       ddr_req;
  logic                       ddr_mode;
  logic [WORDSIZE+LSB-1:0]    ddr_base;
  logic [LWIDTH-1:0]          ddr_len;
  logic                       ddr_we;
  logic [WORDSIZE-1:0]        ddr_waddr;
  logic [BWIDTH-1:0]          ddr_wdata;
  logic [WORDSIZE-1:0]        ddr_raddr;
  logic [BWIDTH-1:0]          ddr_rdata;
  logic [1:0]                 probe_state;

  modport slave (
    input  pre_req, pre_base, read_len, write_len, mem_we, mem_addr, mem_wdata,
           ddr_we, ddr_waddr, ddr_wdata, ddr_raddr,
    output pre_ack, mem_rdata, ddr_req, ddr_mode, ddr_base, ddr_len, ddr_rdata, probe_state
  );

  modport master (
    output pre_req, pre_base, read_len, write_len, mem_we, mem_addr, mem_wdata,
           ddr_we, ddr_waddr, ddr_wdata, ddr_raddr,
    input  pre_ack, mem_rdata, ddr_req, ddr_mode, ddr_base, ddr_len, ddr_rdata, probe_state
  );
endinterface

// File: rtl/ninjin_ddr_buffer.sv
// Purpose: 16-bit host port <-> 32-bit DDR bursts: pre-buffer for burst 0, ping-pong read buffers, packed write post-buffer.
// Latency: mem_rdata and ddr_rdata one cycle after the address; pre_ack one cycle after the last burst-0 beat.
// Backpressure: none; host must not read a burst before its beats land. Ports: clk, xrst, bus (slave).
// Optional: define NINJIN_DDR_BUF_PROBE_EN to drive probe_state with the FSM state (else tied to 0).
module ninjin_ddr_buffer #(
  parameter int DWIDTH    = 16,
  parameter int BWIDTH    = 32,
  parameter int RATE      = 2,
  parameter int RATELOG   = 1,
  parameter int LSB       = 2,
  parameter int WORDSIZE  = 32,
  parameter int MEMSIZE   = 32,
  parameter int LWIDTH    = 16,
  parameter int BURST_MAX = 256,
  parameter int BUFSIZE   = 8
) (
  input logic              clk,
  input logic              xrst,
  ninjin_ddr_buffer_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, READ = 2'd2, WRITE = 2'd3} state_t;
  localparam int KW = WORDSIZE - BUFSIZE;
  localparam logic [LWIDTH-1:0]   BMAX_L = LWIDTH'(BURST_MAX);
  localparam logic [WORDSIZE-1:0] BMAX_W = WORDSIZE'(BURST_MAX);

  state_t state, state_nx;
  logic [WORDSIZE-1:0] base_q;
  logic [LWIDTH-1:0]   rd_words, wr_words;
  // read-burst bookkeeping (one outstanding burst at most)
  logic                rd_busy, fill_pre, fill_buf, act;
  logic [KW-1:0]       fill_k;
  logic [LWIDTH-1:0]   fill_len, beat_cnt;
  logic [KW-1:0]       tag [2];
  logic [1:0]          tag_vld;
  logic [LWIDTH-1:0]   wr_cnt, wr_total;
  // storage
  logic [BWIDTH-1:0]   pre_buf [BURST_MAX];
  logic [BWIDTH-1:0]   pp_buf  [2][BURST_MAX];
  logic [DWIDTH-1:0]   post_lo [BURST_MAX];
  logic [DWIDTH-1:0]   post_hi [BURST_MAX];
  // registered outputs
  logic                        pre_ack_q, ddr_req_q, ddr_mode_q;
  logic [WORDSIZE+LSB-1:0]     ddr_base_q;
  logic [LWIDTH-1:0]           ddr_len_q;
  logic signed [DWIDTH-1:0]    mem_rdata_q;
  logic [BWIDTH-1:0]           ddr_rdata_q;

  // host address decode
  logic [MEMSIZE-1:0]  maddr;
  logic [WORDSIZE-1:0] hb, ho, he, wbase, nk_off, remaining, bd;
  logic [KW-1:0]       hk, nk, bk;
  logic [BUFSIZE-1:0]  hidx, eidx, bidx;
  logic                active, rd_acc, wr_acc, has_next, nk_res, switch_buf;
  logic                beat_ok, beat_last, pre_done, wr_done, flush;
  logic [LWIDTH-1:0]   nk_len, pre_words, pre_len;
  logic [BWIDTH-1:0]   rd_word;

  assign maddr     = bus.mem_addr;
  assign hb        = WORDSIZE'(maddr >> RATELOG);
  assign wbase     = base_q + WORDSIZE'(rd_words);
  assign ho        = hb - base_q;
  assign he        = hb - wbase;
  assign hk        = ho[WORDSIZE-1:BUFSIZE];
  assign hidx      = ho[BUFSIZE-1:0];
  assign eidx      = he[BUFSIZE-1:0];
  assign active    = (state == READ) || (state == WRITE);
  // unsigned offsets wrap huge when below the region base, so one compare bounds both sides
  assign rd_acc    = active && !bus.mem_we && (ho < WORDSIZE'(rd_words));
  assign wr_acc    = active &&  bus.mem_we && (he < WORDSIZE'(wr_words));

  // next-burst prefetch decision for a host read of burst hk
  assign nk        = hk + KW'(1);
  assign nk_off    = {nk, {BUFSIZE{1'b0}}};
  assign has_next  = nk_off < WORDSIZE'(rd_words);
  assign remaining = WORDSIZE'(rd_words) - nk_off;
  assign nk_len    = (remaining > BMAX_W) ? BMAX_L : remaining[LWIDTH-1:0];
  assign nk_res    = (tag_vld[0] && tag[0] == nk) || (tag_vld[1] && tag[1] == nk);
  assign switch_buf = rd_acc && has_next && !nk_res && !rd_busy;

  // beats belonging to anything other than the burst being filled (e.g. stale after a restart) are dropped
  assign bd        = bus.ddr_waddr - base_q;
  assign bk        = bd[WORDSIZE-1:BUFSIZE];
  assign bidx      = bd[BUFSIZE-1:0];
  assign beat_ok   = rd_busy && bus.ddr_we && (bk == fill_k);
  assign beat_last = beat_ok && (beat_cnt + LWIDTH'(1) == fill_len);
  assign pre_done  = beat_last && fill_pre;

  // an entry completes on its odd half; flush on a full burst or at the end of the region
  assign wr_done   = wr_acc && maddr[0];
  assign flush     = wr_done && ((wr_cnt + LWIDTH'(1) == BMAX_L) || (wr_total + LWIDTH'(1) == wr_words));

  assign pre_words = LWIDTH'(bus.read_len / RATE);
  assign pre_len   = (pre_words > BMAX_L) ? BMAX_L : pre_words;

  always_comb begin
    rd_word = pp_buf[1][hidx];
    if (hk == '0)                         rd_word = pre_buf[hidx];
    else if (tag_vld[0] && tag[0] == hk)  rd_word = pp_buf[0][hidx];
  end

  always_comb begin
    state_nx = state;
    if (bus.pre_req) state_nx = PRE;
    else begin
      case (state)
        PRE:         if (pre_done) state_nx = READ;
        READ, WRITE: if (rd_acc) state_nx = READ; else if (wr_acc) state_nx = WRITE;
        default:     state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      base_q <= '0; rd_words <= '0; wr_words <= '0;
      rd_busy <= 1'b0; fill_pre <= 1'b0; fill_buf <= 1'b0; act <= 1'b0;
      fill_k <= '0; fill_len <= '0; beat_cnt <= '0;
      tag[0] <= '0; tag[1] <= '0; tag_vld <= '0;
      wr_cnt <= '0; wr_total <= '0;
      pre_ack_q <= 1'b0; ddr_req_q <= 1'b0; ddr_mode_q <= 1'b0;
      ddr_base_q <= '0; ddr_len_q <= '0;
    end else begin
      ddr_req_q <= 1'b0;
      pre_ack_q <= 1'b0;
      if (bus.pre_req) begin
        base_q   <= bus.pre_base;
        rd_words <= pre_words;
        wr_words <= LWIDTH'(bus.write_len / RATE);
        tag_vld  <= '0; act <= 1'b0;
        rd_busy  <= 1'b1; fill_pre <= 1'b1; fill_k <= '0;
        fill_len <= pre_len; beat_cnt <= '0;
        wr_cnt   <= '0; wr_total <= '0;
        ddr_req_q <= 1'b1; ddr_mode_q <= 1'b0;
        ddr_base_q <= {bus.pre_base, {LSB{1'b0}}};
        ddr_len_q  <= pre_len;
      end else begin
        if (beat_ok) begin
          beat_cnt <= beat_cnt + LWIDTH'(1);
          if (beat_last) begin
            rd_busy <= 1'b0;
            if (fill_pre) pre_ack_q <= 1'b1;
          end
        end
        if (switch_buf) begin
          act <= ~act; fill_buf <= ~act;
          tag[~act] <= nk; tag_vld[~act] <= 1'b1;
          rd_busy <= 1'b1; fill_pre <= 1'b0; fill_k <= nk;
          fill_len <= nk_len; beat_cnt <= '0;
          ddr_req_q <= 1'b1; ddr_mode_q <= 1'b0;
          ddr_base_q <= {base_q + nk_off, {LSB{1'b0}}};
          ddr_len_q  <= nk_len;
        end
        if (wr_done) begin
          if (flush) begin
            wr_cnt   <= '0;
            wr_total <= (wr_total + LWIDTH'(1) == wr_words) ? '0 : wr_total + LWIDTH'(1);
            ddr_req_q <= 1'b1; ddr_mode_q <= 1'b1;
            // first entry of this burst sits wr_cnt entries below the one just completed
            ddr_base_q <= {hb - WORDSIZE'(wr_cnt), {LSB{1'b0}}};
            ddr_len_q  <= wr_cnt + LWIDTH'(1);
          end else begin
            wr_cnt   <= wr_cnt + LWIDTH'(1);
            wr_total <= wr_total + LWIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!bus.pre_req && beat_ok) begin
      if (fill_pre) pre_buf[bidx] <= bus.ddr_wdata;
      else          pp_buf[fill_buf][bidx] <= bus.ddr_wdata;
    end
    if (!bus.pre_req && wr_acc) begin
      if (maddr[0]) post_hi[eidx] <= bus.mem_wdata;
      else          post_lo[eidx] <= bus.mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      mem_rdata_q <= '0;
      ddr_rdata_q <= '0;
    end else begin
      if (!bus.pre_req && rd_acc)
        mem_rdata_q <= $signed(maddr[0] ? rd_word[BWIDTH-1:DWIDTH] : rd_word[DWIDTH-1:0]);
      else if (!bus.pre_req && wr_acc)
        mem_rdata_q <= bus.mem_wdata;
      ddr_rdata_q <= {post_hi[BUFSIZE'(bus.ddr_raddr - wbase)], post_lo[BUFSIZE'(bus.ddr_raddr - wbase)]};
    end
  end

  assign bus.pre_ack   = pre_ack_q;
  assign bus.ddr_req   = ddr_req_q;
  assign bus.ddr_mode  = ddr_mode_q;
  assign bus.ddr_base  = ddr_base_q;
  assign bus.ddr_len   = ddr_len_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.ddr_rdata = ddr_rdata_q;
`ifdef NINJIN_DDR_BUF_PROBE_EN
  assign bus.probe_state = state;
`else
  assign bus.probe_state = 2'b00;
`endif
endmodule

// File: tb/tb_ninjin_ddr_buffer.sv
// Purpose: directed self-checking bench for ninjin_ddr_buffer with a DDR read-beat model and request monitor.
// Latency: checks every host/DDR readback one cycle after its address, sampled on the falling edge.
// Backpressure: none modelled; host pauses 10 cycles after each read-burst request.
module tb_ninjin_ddr_buffer;
  logic clk;
  logic xrst;
  ninjin_ddr_buffer_if bus ();

  ninjin_ddr_buffer dut (.clk(clk), .xrst(xrst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rd_beats = 0, wr_beats = 0;
  int rd_reqs = 0, wr_reqs = 0, pre_fetches = 0;
  logic [33:0] last_wr_base;
  logic [15:0] last_wr_len;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // DDR read model: streams one beat per cycle for each read request
  initial begin
    logic [31:0] b;
    int n;
    bus.ddr_we = 1'b0; bus.ddr_waddr = '0; bus.ddr_wdata = '0;
    forever begin
      @(negedge clk);
      if (!xrst && bus.ddr_req && !bus.ddr_mode) begin
        b = 32'(bus.ddr_base >> 2);
        n = int'(bus.ddr_len);
        for (int i = 0; i < n; i++) begin
          bus.ddr_we = 1'b1;
          bus.ddr_waddr = b + 32'(i);
          bus.ddr_wdata = 32'h0def000c + (b + 32'(i) - 32'h2800);
          rd_beats++;
          @(negedge clk);
        end
        bus.ddr_we = 1'b0;
      end
    end
  end

  // request monitor
  initial begin
    last_wr_base = '0; last_wr_len = '0;
    forever begin
      @(negedge clk);
      if (!xrst && bus.ddr_req) begin
        if (bus.ddr_mode) begin
          wr_reqs++; last_wr_base = bus.ddr_base; last_wr_len = bus.ddr_len;
        end else begin
          rd_reqs++;
          if (bus.ddr_base == 34'h0a000) pre_fetches++;
        end
      end
    end
  end

  initial begin
    repeat (50000) @(negedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic read_pass();
    logic [15:0] exp;
    for (int a = 'h5000; a <= 'h58ff; a++) begin
      bus.mem_we = 1'b0; bus.mem_addr = 32'(a);
      @(negedge clk);
      exp = (a % 2 == 1) ? 16'h0def : 16'(32'h000c + (a - 'h5000) / 2);
      check_val("rd_data", 64'($unsigned(bus.mem_rdata)), 64'(exp));
      if (a == 'h5100) begin
`ifdef NINJIN_DDR_BUF_PROBE_EN
        check_val("probe_read", 64'(bus.probe_state), 64'd2);
`else
        check_val("probe_read", 64'(bus.probe_state), 64'd0);
`endif
      end
      if (bus.ddr_req && !bus.ddr_mode) begin
        bus.mem_addr = '0;
        repeat (10) @(negedge clk);
      end
    end
    bus.mem_addr = '0;
    repeat (20) @(negedge clk);
  endtask

  task automatic write_pass(input int exp_wr_reqs);
    for (int i = 0; i < 128; i++) begin
      bus.mem_we = 1'b1; bus.mem_addr = 32'h5900 + 32'(i); bus.mem_wdata = 16'(i + 5);
      @(negedge clk);
      check_val("wr_echo", 64'($unsigned(bus.mem_rdata)), 64'(i + 5));
      if (i == 10) begin
`ifdef NINJIN_DDR_BUF_PROBE_EN
        check_val("probe_write", 64'(bus.probe_state), 64'd3);
`else
        check_val("probe_write", 64'(bus.probe_state), 64'd0);
`endif
      end
    end
    bus.mem_we = 1'b0; bus.mem_addr = '0;
    @(negedge clk);
    check_val("wr_req_cnt", 64'(wr_reqs), 64'(exp_wr_reqs));
    check_val("wr_base", 64'(last_wr_base), 64'h0b200);
    check_val("wr_len", 64'(last_wr_len), 64'd64);
    for (int j = 0; j < 64; j++) begin
      bus.ddr_raddr = 32'h2c80 + 32'(j);
      @(negedge clk);
      check_val("ddr_rdata", 64'(bus.ddr_rdata), {32'h0, 16'(2 * j + 6), 16'(2 * j + 5)});
      wr_beats++;
    end
  endtask

  initial begin
    int waited;
    xrst = 1'b1;
    bus.pre_req = 1'b0; bus.pre_base = '0; bus.read_len = '0; bus.write_len = '0;
    bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.ddr_raddr = '0;
    repeat (3) @(negedge clk);
    check_val("rst_pre_ack", 64'(bus.pre_ack), 64'd0);
    check_val("rst_ddr_req", 64'(bus.ddr_req), 64'd0);
    check_val("rst_ddr_mode", 64'(bus.ddr_mode), 64'd0);
    check_val("rst_ddr_base", 64'(bus.ddr_base), 64'd0);
    check_val("rst_ddr_len", 64'(bus.ddr_len), 64'd0);
    check_val("rst_mem_rdata", 64'($unsigned(bus.mem_rdata)), 64'd0);
    check_val("rst_ddr_rdata", 64'(bus.ddr_rdata), 64'd0);
    check_val("rst_probe", 64'(bus.probe_state), 64'd0);
    xrst = 1'b0;
    repeat (2) @(negedge clk);

    // setup
    bus.pre_req = 1'b1; bus.pre_base = 32'h2800; bus.read_len = 16'd2304; bus.write_len = 16'd128;
    @(negedge clk);
    bus.pre_req = 1'b0;
    check_val("pre_req_pulse", 64'(bus.ddr_req), 64'd1);
    check_val("pre_mode", 64'(bus.ddr_mode), 64'd0);
    check_val("pre_base", 64'(bus.ddr_base), 64'h0a000);
    check_val("pre_len", 64'(bus.ddr_len), 64'd256);
`ifdef NINJIN_DDR_BUF_PROBE_EN
    check_val("probe_pre", 64'(bus.probe_state), 64'd1);
`else
    check_val("probe_pre", 64'(bus.probe_state), 64'd0);
`endif
    waited = 0;
    while (!bus.pre_ack && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check_val("pre_ack_seen", 64'(bus.pre_ack), 64'd1);
    check_val("pre_req_count", 64'(rd_reqs), 64'd1);
    check_val("pre_beats", 64'(rd_beats), 64'd256);

    read_pass();
    check_val("rd_beats_1", 64'(rd_beats), 64'd1152);
    check_val("rd_reqs_1", 64'(rd_reqs), 64'd5);

    write_pass(1);

    // outside both regions: no effect, rdata holds
    bus.mem_we = 1'b0; bus.mem_addr = 32'h0;
    @(negedge clk);
    check_val("oor_read_hold", 64'($unsigned(bus.mem_rdata)), 64'd132);
    bus.mem_we = 1'b1; bus.mem_addr = 32'h10; bus.mem_wdata = 16'h7777;
    @(negedge clk);
    check_val("oor_write_hold", 64'($unsigned(bus.mem_rdata)), 64'd132);
    bus.mem_we = 1'b1; bus.mem_addr = 32'h5000; bus.mem_wdata = 16'h1234;
    @(negedge clk);
    check_val("write_in_read_region", 64'($unsigned(bus.mem_rdata)), 64'd132);
    bus.mem_we = 1'b0; bus.mem_addr = 32'h5980;
    @(negedge clk);
    check_val("read_past_write_end", 64'($unsigned(bus.mem_rdata)), 64'd132);
    bus.mem_addr = '0;
    repeat (2) @(negedge clk);
    check_val("oor_no_wr_req", 64'(wr_reqs), 64'd1);
    check_val("oor_no_rd_req", 64'(rd_reqs), 64'd5);

    read_pass();
    check_val("rd_beats_2", 64'(rd_beats), 64'd2048);
    check_val("rd_reqs_2", 64'(rd_reqs), 64'd9);
    check_val("burst0_once", 64'(pre_fetches), 64'd1);

    write_pass(2);
    check_val("wr_beats_total", 64'(wr_beats), 64'd128);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
